// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory/peripheral bus between the CPU
// load/store path (M0) and the UART loader/debug port (M1), one transaction at a time.
module mem_port_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_wr,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    input  logic          m1_req,
    input  logic          m1_wr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] rdata_out,
    output logic          s_rd,
    output logic          s_wr,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic [DW-1:0] s_rdata,
    output logic          gnt_id
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

    state_e          state_q;
    logic            s_rd_q;
    logic            s_wr_q;
    logic            m0_ack_q;
    logic            m1_ack_q;
    logic [AW-1:0]   s_addr_q;
    logic [DW-1:0]   s_wdata_q;
    logic [DW-1:0]   rdata_q;
    logic            gnt_q;
    logic            wr_q;
    logic            favour_q;
    logic [CW-1:0]   cnt_q;

    logic            pick_m1_d;
    logic            pick_wr_d;

    // favour_q set means M1 wins a tie; it flips away from whoever was just served.
    assign pick_m1_d = m1_req && (!m0_req || favour_q);
    assign pick_wr_d = pick_m1_d ? m1_wr : m0_wr;

    // Strobes and acks are registered one-cycle pulses, cleared by default every cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            s_rd_q    <= 1'b0;
            s_wr_q    <= 1'b0;
            m0_ack_q  <= 1'b0;
            m1_ack_q  <= 1'b0;
            s_addr_q  <= '0;
            s_wdata_q <= '0;
            rdata_q   <= '0;
            gnt_q     <= 1'b0;
            wr_q      <= 1'b0;
            favour_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s_rd_q   <= 1'b0;
            s_wr_q   <= 1'b0;
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        gnt_q     <= pick_m1_d;
                        wr_q      <= pick_wr_d;
                        s_addr_q  <= pick_m1_d ? m1_addr : m0_addr;
                        s_wdata_q <= pick_m1_d ? m1_wdata : m0_wdata;
                        s_rd_q    <= ~pick_wr_d;
                        s_wr_q    <= pick_wr_d;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (LAT == 1) begin
                        if (!wr_q) begin
                            rdata_q <= s_rdata;
                        end
                        m0_ack_q <= ~gnt_q;
                        m1_ack_q <= gnt_q;
                        state_q  <= ACK;
                    end else begin
                        cnt_q   <= CW'(LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CW'(1)) begin
                        if (!wr_q) begin
                            rdata_q <= s_rdata;
                        end
                        m0_ack_q <= ~gnt_q;
                        m1_ack_q <= gnt_q;
                        state_q  <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                ACK: begin
                    favour_q <= ~gnt_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_rd      = s_rd_q;
    assign s_wr      = s_wr_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign s_addr    = s_addr_q;
    assign s_wdata   = s_wdata_q;
    assign rdata_out = rdata_q;
    assign gnt_id    = gnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=1 and a LAT=3 instance, each checked every cycle
// against a transaction-age reference model, with directed, contention and random phases.
module tb_mem_port_arbiter;

    localparam int ND = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mReq   [ND][2];
    logic        mWr    [ND][2];
    logic [31:0] mAddr  [ND][2];
    logic [31:0] mWdata [ND][2];
    logic        mAck   [ND][2];
    logic [31:0] rdataOut [ND];
    logic [31:0] sAddr    [ND];
    logic [31:0] sWdata   [ND];
    logic [31:0] sRdata   [ND];
    logic        sRd      [ND];
    logic        sWr      [ND];
    logic        gntId    [ND];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : gDut
        mem_port_arbiter #(.AW(32), .DW(32), .LAT(g == 0 ? 1 : 3)) dut (
            .clk       (clk),
            .reset     (reset),
            .m0_req    (mReq[g][0]),
            .m0_wr     (mWr[g][0]),
            .m0_addr   (mAddr[g][0]),
            .m0_wdata  (mWdata[g][0]),
            .m0_ack    (mAck[g][0]),
            .m1_req    (mReq[g][1]),
            .m1_wr     (mWr[g][1]),
            .m1_addr   (mAddr[g][1]),
            .m1_wdata  (mWdata[g][1]),
            .m1_ack    (mAck[g][1]),
            .rdata_out (rdataOut[g]),
            .s_rd      (sRd[g]),
            .s_wr      (sWr[g]),
            .s_addr    (sAddr[g]),
            .s_wdata   (sWdata[g]),
            .s_rdata   (sRdata[g]),
            .gnt_id    (gntId[g])
        );
    end

    // Reference model: a transaction is described by its age in cycles since the grant edge.
    // Age 1 is the strobe cycle, the slave is sampled at the end of age LAT, age LAT+1 is the ack.
    bit          mdActive [ND];
    int          mdAge    [ND];
    bit          mdOwner  [ND];
    bit          mdWr     [ND];
    bit          mdFavour [ND];
    bit          mdGnt    [ND];
    logic [31:0] mdAddr   [ND];
    logic [31:0] mdWdata  [ND];
    logic [31:0] mdRdata  [ND];
    bit          pend     [ND][2];
    int          grantCount [ND];
    int          raisePct = 0;
    bit          allowDrop = 1'b0;
    int          nChecks = 0;
    int          nFails = 0;

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic bit expStrobe(input int d);
        return mdActive[d] && (mdAge[d] == 1);
    endfunction

    function automatic bit expAck(input int d, input int k);
        return mdActive[d] && (mdAge[d] == latOf(d) + 1) && (mdOwner[d] == 1'(k));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input int d);
        checkOutput($sformatf("d%0d.s_rd", d), 32'(sRd[d]), 32'(expStrobe(d) && !mdWr[d]));
        checkOutput($sformatf("d%0d.s_wr", d), 32'(sWr[d]), 32'(expStrobe(d) && mdWr[d]));
        checkOutput($sformatf("d%0d.m0_ack", d), 32'(mAck[d][0]), 32'(expAck(d, 0)));
        checkOutput($sformatf("d%0d.m1_ack", d), 32'(mAck[d][1]), 32'(expAck(d, 1)));
        checkOutput($sformatf("d%0d.gnt_id", d), 32'(gntId[d]), 32'(mdGnt[d]));
        checkOutput($sformatf("d%0d.s_addr", d), sAddr[d], mdAddr[d]);
        checkOutput($sformatf("d%0d.s_wdata", d), sWdata[d], mdWdata[d]);
        checkOutput($sformatf("d%0d.rdata_out", d), rdataOut[d], mdRdata[d]);
    endtask

    task automatic modelReset();
        for (int d = 0; d < ND; d++) begin
            mdActive[d] = 1'b0;
            mdAge[d]    = 0;
            mdOwner[d]  = 1'b0;
            mdWr[d]     = 1'b0;
            mdFavour[d] = 1'b0;
            mdGnt[d]    = 1'b0;
            mdAddr[d]   = '0;
            mdWdata[d]  = '0;
            mdRdata[d]  = '0;
        end
    endtask

    task automatic modelStep(input int d);
        int lat = latOf(d);
        bit r0;
        bit r1;
        bit win;
        if (mdActive[d]) begin
            if (mdAge[d] == lat + 1) begin
                mdActive[d] = 1'b0;
                mdFavour[d] = ~mdOwner[d];
            end else begin
                if (mdAge[d] == lat && !mdWr[d]) mdRdata[d] = sRdata[d];
                mdAge[d]++;
            end
        end else begin
            r0 = mReq[d][0];
            r1 = mReq[d][1];
            if (r0 || r1) begin
                win         = (r0 && r1) ? mdFavour[d] : r1;
                mdActive[d] = 1'b1;
                mdAge[d]    = 1;
                mdOwner[d]  = win;
                mdGnt[d]    = win;
                mdWr[d]     = mWr[d][win];
                mdAddr[d]   = mAddr[d][win];
                mdWdata[d]  = mWdata[d][win];
            end
        end
    endtask

    task automatic clearRequests();
        for (int d = 0; d < ND; d++) begin
            for (int k = 0; k < 2; k++) begin
                pend[d][k] = 1'b0;
                mReq[d][k] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++) checkAll(d);
    endtask

    task automatic stepAll();
        if (reset) begin
            for (int d = 0; d < ND; d++) modelStep(d);
        end
    endtask

    // Random requesters obeying the hold-until-ack protocol; idle ones churn their fields.
    task automatic applyStimulus();
        for (int d = 0; d < ND; d++) begin
            sRdata[d] = $urandom;
            for (int k = 0; k < 2; k++) begin
                if (expAck(d, k)) pend[d][k] = 1'b0;
                if (!pend[d][k]) begin
                    mReq[d][k]   = 1'b0;
                    mWr[d][k]    = 1'($urandom_range(1));
                    mAddr[d][k]  = $urandom;
                    mWdata[d][k] = $urandom;
                    if (int'($urandom_range(99)) < raisePct) begin
                        pend[d][k] = 1'b1;
                        mReq[d][k] = 1'b1;
                    end
                end else if (allowDrop && mdActive[d] && mdOwner[d] == 1'(k) &&
                             mdAge[d] <= latOf(d) && $urandom_range(7) == 0) begin
                    mReq[d][k] = 1'b0;
                end
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < ND; d++) begin
            sRdata[d] = '0;
            for (int k = 0; k < 2; k++) begin
                mReq[d][k]   = 1'b0;
                mWr[d][k]    = 1'b0;
                mAddr[d][k]  = '0;
                mWdata[d][k] = '0;
                pend[d][k]   = 1'b0;
            end
        end
        modelReset();

        // Requests already pending while reset is held; M0 must win the first tie.
        mReq[0][0] = 1'b1; mAddr[0][0] = 32'h4000_0010; sRdata[0] = 32'h1234_5678;
        mReq[1][0] = 1'b1; mAddr[1][0] = 32'h0000_0100; sRdata[1] = 32'hCAFE_F00D;
        mReq[1][1] = 1'b1; mWr[1][1] = 1'b1; mAddr[1][1] = 32'h4000_000C; mWdata[1][1] = 32'h0000_00A5;
        #1;
        checkAll(0);
        checkAll(1);
        repeat (3) tick();

        for (int n = 0; n <= 10; n++) begin
            tick();
            case (n)
                0: reset = 1'b1;
                1: begin
                    checkOutput("lat1.issue.s_rd", 32'(sRd[0]), 32'd1);
                    checkOutput("lat1.issue.s_addr", sAddr[0], 32'h4000_0010);
                    checkOutput("lat3.tie.gnt_id", 32'(gntId[1]), 32'd0);
                end
                2: begin
                    checkOutput("lat1.ack", 32'(mAck[0][0]), 32'd1);
                    checkOutput("lat1.rdata", rdataOut[0], 32'h1234_5678);
                    mAddr[0][0] = 32'h0000_0008;
                end
                3: begin
                    checkOutput("lat1.idle.s_rd", 32'(sRd[0]), 32'd0);
                    sRdata[0] = 32'h0BAD_BEEF;
                end
                4: begin
                    checkOutput("b2b.issue.s_rd", 32'(sRd[0]), 32'd1);
                    checkOutput("b2b.s_addr", sAddr[0], 32'h0000_0008);
                    checkOutput("lat3.read.ack", 32'(mAck[1][0]), 32'd1);
                    checkOutput("lat3.read.rdata", rdataOut[1], 32'hCAFE_F00D);
                    mReq[1][0] = 1'b0;
                end
                5: begin
                    checkOutput("b2b.ack", 32'(mAck[0][0]), 32'd1);
                    checkOutput("b2b.rdata", rdataOut[0], 32'h0BAD_BEEF);
                    mReq[0][0] = 1'b0;
                end
                6: begin
                    checkOutput("lat3.wr.s_wr", 32'(sWr[1]), 32'd1);
                    checkOutput("lat3.wr.s_rd", 32'(sRd[1]), 32'd0);
                    checkOutput("lat3.wr.s_addr", sAddr[1], 32'h4000_000C);
                    checkOutput("lat3.wr.s_wdata", sWdata[1], 32'h0000_00A5);
                    checkOutput("lat3.wr.gnt_id", 32'(gntId[1]), 32'd1);
                end
                7: mReq[1][1] = 1'b0;
                9: begin
                    checkOutput("lat3.wr.m1_ack", 32'(mAck[1][1]), 32'd1);
                    checkOutput("lat3.wr.m0_ack", 32'(mAck[1][0]), 32'd0);
                    checkOutput("lat3.wr.rdata_held", rdataOut[1], 32'hCAFE_F00D);
                end
                default: ;
            endcase
            stepAll();
        end

        // Fresh reset, then both masters request continuously: grants must alternate from M0.
        tick();
        reset = 1'b0;
        clearRequests();
        modelReset();
        #1;
        checkAll(0);
        checkAll(1);
        raisePct = 100;
        allowDrop = 1'b0;
        grantCount[0] = 0;
        grantCount[1] = 0;
        for (int n = 0; n < 80 && (grantCount[0] < 6 || grantCount[1] < 6); n++) begin
            tick();
            for (int d = 0; d < ND; d++) begin
                if (expStrobe(d)) begin
                    checkOutput($sformatf("contention%0d.order", d), 32'(gntId[d]),
                                32'(grantCount[d] % 2));
                    grantCount[d]++;
                end
            end
            reset = 1'b1;
            applyStimulus();
            stepAll();
        end

        // Reset lands while the LAT=3 instance is waiting on the slave.
        for (int n = 0; n < 20 && reset; n++) begin
            tick();
            if (mdActive[1] && mdAge[1] == 2) begin
                reset = 1'b0;
                clearRequests();
                modelReset();
                #1;
                checkOutput("midreset.s_rd", 32'(sRd[1]), 32'd0);
                checkOutput("midreset.s_wr", 32'(sWr[1]), 32'd0);
                checkAll(0);
                checkAll(1);
            end else begin
                applyStimulus();
                stepAll();
            end
        end
        repeat (2) tick();
        tick();
        reset = 1'b1;
        raisePct = 0;
        applyStimulus();
        stepAll();
        for (int n = 0; n < 6; n++) begin
            tick();
            checkOutput("postreset.m0_ack", 32'(mAck[1][0]), 32'd0);
            checkOutput("postreset.m1_ack", 32'(mAck[1][1]), 32'd0);
            applyStimulus();
            stepAll();
        end

        // Random traffic with mid-transaction req drops and occasional asynchronous resets.
        raisePct = 40;
        allowDrop = 1'b1;
        for (int n = 0; n < 400; n++) begin
            tick();
            if (!reset) begin
                reset = 1'b1;
            end else if ($urandom_range(149) == 0) begin
                reset = 1'b0;
                clearRequests();
                modelReset();
                #1;
                checkAll(0);
                checkAll(1);
            end
            if (reset) applyStimulus();
            stepAll();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
